// File: rtl/cpu_clk_ctrl.sv
// cpu_clk_ctrl: turns divided-clock edges into CPU enables gated by a debounced run/halt/step FSM.
// Define CPU_CLK_CTRL_BREAK_EN to add the break_cycle/break_hit breakpoint.
module cpu_clk_ctrl #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             slow_clk_in,
  input  logic             btn_run,
  input  logic             btn_step,
  input  logic             btn_halt,
`ifdef CPU_CLK_CTRL_BREAK_EN
  input  logic [CNT_W-1:0] break_cycle,
  output logic             break_hit,
`endif
  output logic             cpu_en,
  output logic             running,
  output logic [CNT_W-1:0] cycle_count
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  typedef enum logic [1:0] {HALT, RUN, STEP} state_t;
  state_t state, state_next;
  logic s1, s2, s3, tick, en_next, brk;
  logic [2:0] btn, press;
  assign btn = {btn_halt, btn_step, btn_run};
  assign tick = s2 & ~s3;
  for (genvar b = 0; b < 3; b++) begin : g_db
    logic b1, b2, db;
    logic [DW-1:0] cnt;
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        b1 <= 1'b0;
        b2 <= 1'b0;
        db <= 1'b0;
        cnt <= '0;
      end else begin
        b1 <= btn[b];
        b2 <= b1;
        if (b2 == db) cnt <= '0;
        else if (cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
          db <= ~db;
          cnt <= '0;
        end else cnt <= cnt + DW'(1);
      end
    // fires in the cycle the debounced state is about to flip 0->1
    assign press[b] = (b2 != db) && (cnt == DW'(DEBOUNCE_CYCLES - 1)) && !db;
  end
`ifdef CPU_CLK_CTRL_BREAK_EN
  assign brk = state == RUN && en_next && break_cycle != '0 && cycle_count + CNT_W'(1) == break_cycle;
  always_ff @(posedge clk or posedge rst)
    if (rst) break_hit <= 1'b0;
    else if (brk) break_hit <= 1'b1;
    else if (press[0] || press[1]) break_hit <= 1'b0;
`else
  assign brk = 1'b0;
`endif
  always_comb begin
    state_next = state;
    en_next = tick && !press[2] && state != HALT;
    if (press[2]) state_next = HALT;
    else if (state == HALT) state_next = press[1] ? STEP : press[0] ? RUN : HALT;
    else if (brk || (state == STEP && tick)) state_next = HALT;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= HALT;
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
      cpu_en <= 1'b0;
      running <= 1'b0;
      cycle_count <= '0;
    end else begin
      state <= state_next;
      s1 <= slow_clk_in;
      s2 <= s1;
      s3 <= s2;
      cpu_en <= en_next;
      running <= state_next == RUN;
      cycle_count <= cycle_count + CNT_W'(en_next);
    end
endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// tb_cpu_clk_ctrl: scoreboard bench; slow-clock rises push expected pulses, a monitor pops them.
module tb_cpu_clk_ctrl;
  logic clk = 0, rst = 0, slow = 0, btn_run = 0, btn_step = 0, btn_halt = 0;
  logic cpu_en, running;
  logic [3:0] cycle_count;
`ifdef CPU_CLK_CTRL_BREAK_EN
  logic [3:0] break_cycle = 0;
  logic break_hit;
`endif
  always #5 clk = ~clk;

  cpu_clk_ctrl #(.DEBOUNCE_CYCLES(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .slow_clk_in(slow),
    .btn_run(btn_run), .btn_step(btn_step), .btn_halt(btn_halt),
`ifdef CPU_CLK_CTRL_BREAK_EN
    .break_cycle(break_cycle), .break_hit(break_hit),
`endif
    .cpu_en(cpu_en), .running(running), .cycle_count(cycle_count)
  );

  typedef struct {int cyc; logic [3:0] cnt;} exp_t;
  exp_t q[$];
  exp_t e;
  int cyc = 0, falls = 0, checks = 0, errors = 0, mode = 0, budget = -1;
  logic [3:0] exp_cnt = 0;
  logic prev_en = 0;

  always @(posedge clk) cyc++;

  // mode 1: every rise expects a pulse (while budget lasts); mode 2: next rise only
  initial forever begin
    repeat (10) @(negedge clk);
    slow = ~slow;
    if (!slow) falls++;
    else if ((mode == 1 && budget != 0) || mode == 2) begin
      exp_cnt++;
      q.push_back('{cyc + 3, exp_cnt});
      if (mode == 2) mode = 0;
      if (budget > 0) budget--;
    end
  end

  always @(negedge clk) begin
    if (!rst && cpu_en) begin
      checks++;
      if (prev_en) begin
        errors++;
        $display("FAIL pulse_width: cpu_en high 2 cycles at cyc %0d, required 1", cyc);
      end else if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: cpu_en at cyc %0d count %0d, required none", cyc, cycle_count);
      end else begin
        e = q.pop_front();
        if (cyc != e.cyc || cycle_count != e.cnt) begin
          errors++;
          $display("FAIL pulse: cyc %0d count %0d, required cyc %0d count %0d", cyc, cycle_count, e.cyc, e.cnt);
        end
      end
    end
    prev_en = cpu_en;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic press(input logic [2:0] b, input int n);
    @(negedge clk);
    {btn_halt, btn_step, btn_run} = b;
    repeat (n) @(negedge clk);
    {btn_halt, btn_step, btn_run} = 3'b000;
  endtask

  task automatic wait_falls(input int n);
    int t;
    t = falls + n;
    while (falls < t) @(negedge clk);
  endtask

  task automatic do_reset();
    wait_falls(1);
    @(negedge clk);
    rst = 1;
    q.delete();
    exp_cnt = 0;
    mode = 0;
    budget = -1;
    prev_en = 0;
    repeat (2) @(negedge clk);
    chk("rst_cpu_en", cpu_en, 0);
    chk("rst_running", running, 0);
    chk("rst_count", cycle_count, 0);
`ifdef CPU_CLK_CTRL_BREAK_EN
    chk("rst_break_hit", break_hit, 0);
`endif
    rst = 0;
    wait_falls(1);
  endtask

  initial begin
    do_reset();
    repeat (200) @(negedge clk);
    chk("idle_running", running, 0);
    chk("idle_count", cycle_count, 0);
    chk("idle_queue", q.size(), 0);

    mode = 1;
    press(3'b001, 6);
    @(negedge clk);
    chk("run_running", running, 1);
    wait_falls(10);
    mode = 0;
    press(3'b100, 6);
    @(negedge clk);
    chk("run_halt_running", running, 0);
    chk("run_count", cycle_count, 10);
    chk("run_queue", q.size(), 0);

    do_reset();
    mode = 2;
    press(3'b010, 6);
    wait_falls(1);
    chk("step1_count", cycle_count, 1);
    chk("step1_running", running, 0);
    chk("step1_queue", q.size(), 0);
    wait_falls(2);
    chk("step1_hold", cycle_count, 1);
    mode = 2;
    press(3'b010, 6);
    wait_falls(1);
    chk("step2_count", cycle_count, 2);

    do_reset();
    mode = 1;
    press(3'b001, 6);
    wait_falls(2);
    mode = 0;
    press(3'b101, 6);
    @(negedge clk);
    chk("halt_run_running", running, 0);
    wait_falls(3);
    chk("halt_run_count", cycle_count, 2);
    chk("halt_run_queue", q.size(), 0);
    press(3'b001, 2);
    wait_falls(2);
    chk("glitch_running", running, 0);
    chk("glitch_count", cycle_count, 2);

    do_reset();
    mode = 1;
    press(3'b001, 6);
    wait_falls(15);
    mode = 0;
    press(3'b100, 6);
    chk("wrap_pre_count", cycle_count, 15);
    wait_falls(1);
    mode = 2;
    press(3'b010, 6);
    wait_falls(1);
    chk("wrap_count", cycle_count, 0);
    chk("wrap_queue", q.size(), 0);

`ifdef CPU_CLK_CTRL_BREAK_EN
    do_reset();
    break_cycle = 5;
    mode = 1;
    budget = 5;
    press(3'b001, 6);
    wait_falls(7);
    chk("brk_hit", break_hit, 1);
    chk("brk_running", running, 0);
    chk("brk_count", cycle_count, 5);
    chk("brk_queue", q.size(), 0);
    mode = 1;
    budget = 3;
    press(3'b001, 6);
    @(negedge clk);
    chk("brk_clear", break_hit, 0);
    chk("brk_rerun", running, 1);
    wait_falls(3);
    mode = 0;
    press(3'b100, 6);
    wait_falls(1);
    chk("brk_resume_count", cycle_count, 8);
    chk("brk_resume_queue", q.size(), 0);
`endif

    wait_falls(1);
    chk("final_queue", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
